// File: rtl/rd_arb_pkg.sv
// rd_arb_pkg -- shared widths and helpers for the two-source AXI read arbiter.
//   ID_W / ADDR_W / DATA_W : AXI ID, address and data widths
//   SRC_BIT                : ID bit that carries the source index downstream
//   OUTST_W                : width of the per-source outstanding counter (max 255)
package rd_arb_pkg;

    localparam int ID_W    = 16;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 512;
    localparam int SRC_BIT = 15;
    localparam int OUTST_W = 8;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_e;

    // Downstream ID: source index in the top bit, lower bits from the requester.
    function automatic logic [ID_W-1:0] tag_id(input logic src, input logic [SRC_BIT-1:0] id);
        return {src, id};
    endfunction

    // Outstanding counter update; a simultaneous issue and completion cancel out.
    function automatic logic [OUTST_W-1:0] outst_next(input logic [OUTST_W-1:0] cur,
                                                     input logic inc, input logic dec);
        logic [OUTST_W-1:0] nxt;
        nxt = cur;
        case ({inc, dec})
            2'b10:   nxt = cur + 8'd1;
            2'b01:   nxt = cur - 8'd1;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/axi_rd_arb_if.sv
// axi_rd_arb_if -- one AXI read port (AR + R channels).
//   master modport : the side issuing AR and accepting R (requester view)
//   slave  modport : the side accepting AR and returning R
interface axi_rd_arb_if;
    import rd_arb_pkg::*;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/rd_arb_rr.sv
// rd_arb_rr -- two-way round-robin grant with a registered priority pointer.
//   clk, rst  : clock, asynchronous active-low reset
//   i_free    : downstream output register can accept a request this cycle
//   i_elig0/1 : source has a request and room for another outstanding read
//   o_gnt0/1  : one-hot grant (combinational)
module rd_arb_rr
    import rd_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_free,
    input  logic i_elig0,
    input  logic i_elig1,
    output logic o_gnt0,
    output logic o_gnt1
);

    src_e r_ptr;
    logic w_gnt0;
    logic w_gnt1;

    // Grant selection: pointer breaks the tie only when both are eligible.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (i_free) begin
            if (i_elig0 && (!i_elig1 || (r_ptr == SRC0))) begin
                w_gnt0 = 1'b1;
            end else if (i_elig1) begin
                w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = 1'b0;
                w_gnt1 = 1'b0;
            end
        end else begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    // Priority pointer: after any grant, favour the other source.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= SRC0;
        end else if (w_gnt0) begin
            r_ptr <= SRC1;
        end else if (w_gnt1) begin
            r_ptr <= SRC0;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_gnt0 = w_gnt0;
    assign o_gnt1 = w_gnt1;

endmodule

// File: rtl/axi_rd_arb.sv
// axi_rd_arb -- merges two AXI read requesters onto one downstream read port.
//   clk, rst       : clock, asynchronous active-low reset
//   s0, s1         : upstream requester ports (slave modport)
//   m              : shared downstream port (master modport); AR is fully registered
//   perf_grant0/1  : per-source grant counters
//   perf_stall0/1  : per-source cycles with arvalid high and arready low
// Optional feature: define AXI_RD_ARB_PERF_EN to build the perf counters;
// otherwise the perf outputs are tied to zero.
module axi_rd_arb
    import rd_arb_pkg::*;
#(
    parameter int MAX_OUTST = 32
) (
    input  logic        clk,
    input  logic        rst,
    axi_rd_arb_if.slave  s0,
    axi_rd_arb_if.slave  s1,
    axi_rd_arb_if.master m,
    output logic [31:0] perf_grant0,
    output logic [31:0] perf_grant1,
    output logic [31:0] perf_stall0,
    output logic [31:0] perf_stall1
);

    localparam logic [OUTST_W-1:0] MAX_O = OUTST_W'(MAX_OUTST);

    logic [ID_W-1:0]    r_arid;
    logic [ADDR_W-1:0]  r_araddr;
    logic [7:0]         r_arlen;
    logic [2:0]         r_arsize;
    logic               r_arvalid;
    logic [OUTST_W-1:0] r_outst0;
    logic [OUTST_W-1:0] r_outst1;

    logic w_free;
    logic w_gnt0;
    logic w_gnt1;
    logic w_dec0;
    logic w_dec1;
    logic w_rsel;

    // Upstream arid[15] is replaced by the source index.
    logic w_unused_s;
    assign w_unused_s = &{1'b0, s0.arid[SRC_BIT], s1.arid[SRC_BIT]};

    assign w_free = !r_arvalid || m.arready;

    rd_arb_rr u_rr (
        .clk     (clk),
        .rst     (rst),
        .i_free  (w_free),
        .i_elig0 (s0.arvalid && (r_outst0 < MAX_O)),
        .i_elig1 (s1.arvalid && (r_outst1 < MAX_O)),
        .o_gnt0  (w_gnt0),
        .o_gnt1  (w_gnt1)
    );

    assign s0.arready = w_gnt0;
    assign s1.arready = w_gnt1;

    // Output register: load on grant, drop valid once accepted with nothing new.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_arvalid <= 1'b0;
            r_arid    <= 16'h0000;
            r_araddr  <= 64'h0;
            r_arlen   <= 8'h00;
            r_arsize  <= 3'b000;
        end else if (w_gnt0) begin
            r_arvalid <= 1'b1;
            r_arid    <= tag_id(SRC0, s0.arid[SRC_BIT-1:0]);
            r_araddr  <= s0.araddr;
            r_arlen   <= s0.arlen;
            r_arsize  <= s0.arsize;
        end else if (w_gnt1) begin
            r_arvalid <= 1'b1;
            r_arid    <= tag_id(SRC1, s1.arid[SRC_BIT-1:0]);
            r_araddr  <= s1.araddr;
            r_arlen   <= s1.arlen;
            r_arsize  <= s1.arsize;
        end else if (m.arready) begin
            r_arvalid <= 1'b0;
        end else begin
            r_arvalid <= r_arvalid;
        end
    end

    assign m.arid    = r_arid;
    assign m.araddr  = r_araddr;
    assign m.arlen   = r_arlen;
    assign m.arsize  = r_arsize;
    assign m.arvalid = r_arvalid;

    // R routing follows the source bit stamped into the ID on the way out.
    assign w_rsel    = m.rid[SRC_BIT];
    assign s0.rvalid = m.rvalid && !w_rsel;
    assign s1.rvalid = m.rvalid && w_rsel;
    assign m.rready  = w_rsel ? s1.rready : s0.rready;
    assign s0.rid    = {1'b0, m.rid[SRC_BIT-1:0]};
    assign s1.rid    = {1'b0, m.rid[SRC_BIT-1:0]};
    assign s0.rdata  = m.rdata;
    assign s1.rdata  = m.rdata;
    assign s0.rresp  = m.rresp;
    assign s1.rresp  = m.rresp;
    assign s0.rlast  = m.rlast;
    assign s1.rlast  = m.rlast;

    // A completion against an empty counter is a stray response and is dropped.
    assign w_dec0 = s0.rvalid && s0.rready && m.rlast && (r_outst0 != 8'd0);
    assign w_dec1 = s1.rvalid && s1.rready && m.rlast && (r_outst1 != 8'd0);

    // Per-source outstanding read counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outst0 <= 8'd0;
            r_outst1 <= 8'd0;
        end else begin
            r_outst0 <= outst_next(r_outst0, w_gnt0, w_dec0);
            r_outst1 <= outst_next(r_outst1, w_gnt1, w_dec1);
        end
    end

`ifdef AXI_RD_ARB_PERF_EN
    logic [31:0] r_pg0;
    logic [31:0] r_pg1;
    logic [31:0] r_ps0;
    logic [31:0] r_ps1;

    // Free-running grant/stall counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pg0 <= 32'd0;
            r_pg1 <= 32'd0;
            r_ps0 <= 32'd0;
            r_ps1 <= 32'd0;
        end else begin
            r_pg0 <= r_pg0 + {31'd0, w_gnt0};
            r_pg1 <= r_pg1 + {31'd0, w_gnt1};
            r_ps0 <= r_ps0 + {31'd0, (s0.arvalid && !w_gnt0)};
            r_ps1 <= r_ps1 + {31'd0, (s1.arvalid && !w_gnt1)};
        end
    end

    assign perf_grant0 = r_pg0;
    assign perf_grant1 = r_pg1;
    assign perf_stall0 = r_ps0;
    assign perf_stall1 = r_ps1;
`else
    assign perf_grant0 = 32'd0;
    assign perf_grant1 = 32'd0;
    assign perf_stall0 = 32'd0;
    assign perf_stall1 = 32'd0;
`endif

endmodule

// File: tb/tb_axi_rd_arb.sv
// tb_axi_rd_arb -- self-checking bench for axi_rd_arb (MAX_OUTST=2).
// A cycle model predicts grants; each predicted downstream AR is queued and
// compared when it appears on the m port. Perf expectations follow
// AXI_RD_ARB_PERF_EN.
module tb_axi_rd_arb;
    import rd_arb_pkg::*;

    localparam int MAXO = 2;
`ifdef AXI_RD_ARB_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] pg0, pg1, ps0, ps1;

    axi_rd_arb_if s0i ();
    axi_rd_arb_if s1i ();
    axi_rd_arb_if mi ();

    axi_rd_arb #(.MAX_OUTST(MAXO)) dut (
        .clk         (clk),
        .rst         (rst),
        .s0          (s0i),
        .s1          (s1i),
        .m           (mi),
        .perf_grant0 (pg0),
        .perf_grant1 (pg1),
        .perf_stall0 (ps0),
        .perf_stall1 (ps1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] id;
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t exp_q[$];
    int  checks;
    int  failures;

    // model state
    logic        mv;
    logic        ptr;
    int          o0, o1;
    logic [31:0] mg0, mg1, ms0, ms1;
    ar_t         last_ar;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mv = 1'b0; ptr = 1'b0; o0 = 0; o1 = 0;
        mg0 = 32'd0; mg1 = 32'd0; ms0 = 32'd0; ms1 = 32'd0;
        last_ar = '0;
        exp_q.delete();
    endtask

    task automatic drive_ar(input int src, input logic v, input logic [15:0] id, input logic [63:0] addr);
        if (src == 0) begin
            s0i.arvalid = v; s0i.arid = id; s0i.araddr = addr;
            s0i.arlen = addr[7:0]; s0i.arsize = 3'd6;
        end else begin
            s1i.arvalid = v; s1i.arid = id; s1i.araddr = addr;
            s1i.arlen = addr[7:0]; s1i.arsize = 3'd6;
        end
    endtask

    task automatic drive_r(input logic v, input logic [15:0] id, input logic last, input logic [63:0] d);
        mi.rvalid = v; mi.rid = id; mi.rlast = last;
        mi.rdata = {8{d}}; mi.rresp = d[1:0];
    endtask

    // One clock: check combinational outputs, predict, then check registered outputs.
    task automatic step();
        logic fr, e0, e1, g0, g1, rv0, rv1, d0, d1;
        ar_t  e;
        #3;
        fr = !mv || mi.arready;
        e0 = s0i.arvalid && (o0 < MAXO);
        e1 = s1i.arvalid && (o1 < MAXO);
        g0 = fr && e0 && (!e1 || (ptr == 1'b0));
        g1 = fr && e1 && !g0;
        check_val("s0_arready", {63'd0, s0i.arready}, {63'd0, g0});
        check_val("s1_arready", {63'd0, s1i.arready}, {63'd0, g1});
        rv0 = mi.rvalid && !mi.rid[15];
        rv1 = mi.rvalid && mi.rid[15];
        check_val("s0_rvalid", {63'd0, s0i.rvalid}, {63'd0, rv0});
        check_val("s1_rvalid", {63'd0, s1i.rvalid}, {63'd0, rv1});
        check_val("m_rready", {63'd0, mi.rready}, {63'd0, (mi.rid[15] ? s1i.rready : s0i.rready)});
        if (mi.rvalid) begin
            check_val("r_rid", {48'd0, (mi.rid[15] ? s1i.rid : s0i.rid)}, {48'd0, 1'b0, mi.rid[14:0]});
            check_val("r_rdata", (mi.rid[15] ? s1i.rdata[511:448] : s0i.rdata[63:0]), mi.rdata[63:0]);
            check_val("r_rlast", {63'd0, (mi.rid[15] ? s1i.rlast : s0i.rlast)}, {63'd0, mi.rlast});
        end
        if (g0) exp_q.push_back({1'b0, s0i.arid[14:0], s0i.araddr, s0i.arlen});
        if (g1) exp_q.push_back({1'b1, s1i.arid[14:0], s1i.araddr, s1i.arlen});
        d0 = rv0 && s0i.rready && mi.rlast && (o0 != 0);
        d1 = rv1 && s1i.rready && mi.rlast && (o1 != 0);
        o0 = o0 + (g0 ? 1 : 0) - (d0 ? 1 : 0);
        o1 = o1 + (g1 ? 1 : 0) - (d1 ? 1 : 0);
        mg0 = mg0 + {31'd0, g0};
        mg1 = mg1 + {31'd0, g1};
        ms0 = ms0 + {31'd0, (s0i.arvalid && !g0)};
        ms1 = ms1 + {31'd0, (s1i.arvalid && !g1)};
        if (g0) ptr = 1'b1;
        else if (g1) ptr = 1'b0;
        if (g0 || g1) mv = 1'b1;
        else if (mi.arready) mv = 1'b0;
        @(posedge clk);
        #1;
        check_val("m_arvalid", {63'd0, mi.arvalid}, {63'd0, mv});
        if (g0 || g1) begin
            if (exp_q.size() == 0) begin
                check_val("queue_empty", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                last_ar = e;
            end
        end
        if (mv) begin
            check_val("m_arid", {48'd0, mi.arid}, {48'd0, last_ar.id});
            check_val("m_araddr", mi.araddr, last_ar.addr);
            check_val("m_arlen", {56'd0, mi.arlen}, {56'd0, last_ar.len});
            check_val("m_arsize", {61'd0, mi.arsize}, 64'd6);
        end
        check_val("perf_grant0", {32'd0, pg0}, {32'd0, (PERF_EN ? mg0 : 32'd0)});
        check_val("perf_grant1", {32'd0, pg1}, {32'd0, (PERF_EN ? mg1 : 32'd0)});
        check_val("perf_stall0", {32'd0, ps0}, {32'd0, (PERF_EN ? ms0 : 32'd0)});
        check_val("perf_stall1", {32'd0, ps1}, {32'd0, (PERF_EN ? ms1 : 32'd0)});
    endtask

    // Asynchronous reset pulse; outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_val("rst_arvalid", {63'd0, mi.arvalid}, 64'd0);
        check_val("rst_arid", {48'd0, mi.arid}, 64'd0);
        check_val("rst_araddr", mi.araddr, 64'd0);
        check_val("rst_perf", {pg0 | pg1, ps0 | ps1}, 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0;
        drive_ar(0, 1'b0, 16'h0, 64'h0);
        drive_ar(1, 1'b0, 16'h0, 64'h0);
        drive_r(1'b0, 16'h0, 1'b0, 64'h0);
        s0i.rready = 1'b1; s1i.rready = 1'b1; mi.arready = 1'b1;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // both sources every cycle: alternating source bit, first grant to s0
        for (int k = 0; k < 4; k++) begin
            drive_ar(0, 1'b1, 16'h8010 + 16'(k), 64'h1000 + 64'(k));
            drive_ar(1, 1'b1, 16'h0120 + 16'(k), 64'h2000 + 64'(k));
            step();
            check_val("alt_src", {63'd0, mi.arid[15]}, (k % 2 == 0) ? 64'd0 : 64'd1);
        end
        drive_ar(0, 1'b0, 16'h0, 64'h0);
        drive_ar(1, 1'b0, 16'h0, 64'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive_r(1'b1, (k < 2) ? 16'h0011 : 16'h8022, 1'b1, 64'hA0 + 64'(k));
            step();
        end
        drive_r(1'b0, 16'h0, 1'b0, 64'h0);

        // outstanding limit blocks s0 while s1 still wins; an rlast reopens s0
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive_ar(0, 1'b1, 16'h0030 + 16'(k), 64'h3000 + 64'(k));
            step();
        end
        for (int k = 0; k < 2; k++) begin
            drive_ar(1, 1'b1, 16'h0040 + 16'(k), 64'h4000 + 64'(k));
            step();
        end
        drive_ar(1, 1'b0, 16'h0, 64'h0);
        drive_r(1'b1, 16'h0005, 1'b1, 64'h55);
        step();
        drive_r(1'b0, 16'h0, 1'b0, 64'h0);
        step();
        check_val("regrant_s0", {63'd0, mi.arid[15]}, 64'd0);
        drive_ar(0, 1'b0, 16'h0, 64'h0);
        step();

        // downstream back-pressure: payload held, no upstream ready, stalls counted
        do_reset();
        mi.arready = 1'b0;
        drive_ar(0, 1'b1, 16'h0050, 64'h5000);
        step();
        drive_ar(0, 1'b1, 16'h0051, 64'h5001);
        repeat (5) step();
        check_val("stall5", {32'd0, ps0}, PERF_EN ? 64'd5 : 64'd0);
        mi.arready = 1'b1;
        step();
        drive_ar(0, 1'b0, 16'h0, 64'h0);
        step();

        // 4-beat burst to s1, with one beat held by s1_rready=0
        for (int k = 0; k < 4; k++) begin
            drive_r(1'b1, 16'h8003, (k == 3), 64'hBEEF0000 + 64'(k));
            if (k == 1) begin
                s1i.rready = 1'b0;
                step();
                check_val("burst_stall", {63'd0, mi.rready}, 64'd0);
                s1i.rready = 1'b1;
            end
            step();
        end
        drive_r(1'b0, 16'h0, 1'b0, 64'h0);

        // grant and rlast on s0 in the same cycle leave the counter unchanged
        do_reset();
        drive_ar(0, 1'b1, 16'h0060, 64'h6000);
        step();
        drive_ar(0, 1'b1, 16'h0061, 64'h6001);
        drive_r(1'b1, 16'h0060, 1'b1, 64'h66);
        step();
        drive_r(1'b0, 16'h0, 1'b0, 64'h0);
        drive_ar(0, 1'b1, 16'h0062, 64'h6002);
        step();
        step();
        check_val("limit_after_same", {63'd0, s0i.arready}, 64'd0);
        drive_r(1'b1, 16'h0061, 1'b1, 64'h67);
        step();
        drive_r(1'b0, 16'h0, 1'b0, 64'h0);
        mi.arready = 1'b0;
        step();

        // reset mid-operation, then a stray rlast must not underflow
        drive_ar(0, 1'b0, 16'h0, 64'h0);
        do_reset();
        mi.arready = 1'b1;
        drive_r(1'b1, 16'h0070, 1'b1, 64'h77);
        step();
        drive_r(1'b0, 16'h0, 1'b0, 64'h0);
        for (int k = 0; k < 3; k++) begin
            drive_ar(0, 1'b1, 16'h0070 + 16'(k), 64'h7000 + 64'(k));
            step();
        end
        drive_ar(0, 1'b0, 16'h0, 64'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
